// File: rtl/seven_segment_capture.sv
// Snoops the multiplexed seven-segment scan lines and rebuilds the displayed 16-bit value and DP mask.
// Optional DP capture is enabled by defining SEVEN_SEG_CAPTURE_DP_EN.
module seven_segment_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [7:0]  segment,
  output logic [15:0] data_out,
  output logic [3:0]  dp_out,
  output logic        frame_valid,
  output logic        decode_error,
  output logic        stale
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  logic [7:0]    seg_in;
  logic [3:0]    sample_anode;
  logic [7:0]    sample_seg;
  logic [SW-1:0] stable_cnt;
  logic          held;
  logic          changed;
  logic [6:0]    seg_on;
  logic [3:0]    nibble;
  logic          bad;
  logic          digit_ok;
  logic [1:0]    idx;
  logic          capture;
  logic          frame_done;
  logic [15:0]   work_data;
  logic [3:0]    work_err;
  logic [3:0]    seen;
  logic [3:0]    seen_next;
  logic [3:0]    err_next;
  logic [TW-1:0] timeout_cnt;

`ifdef SEVEN_SEG_CAPTURE_DP_EN
  assign seg_in = segment;
`else
  logic dp_unused;
  assign dp_unused = segment[7];
  assign seg_in    = {1'b0, segment[6:0]};
`endif

  assign changed = ({anode, seg_in} != {sample_anode, sample_seg});

  // held marks that the current stable interval has already produced its capture
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_anode <= '0;
      sample_seg   <= '0;
      stable_cnt   <= '0;
      held         <= 1'b0;
    end else begin
      sample_anode <= anode;
      sample_seg   <= seg_in;
      if (changed) begin
        stable_cnt <= '0;
        held       <= 1'b0;
      end else if (stable_cnt == STABLE_MAX) begin
        held <= 1'b1;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  assign seg_on = ~sample_seg[6:0];

  always_comb begin
    nibble = 4'h0;
    bad    = 1'b0;
    case (seg_on)
      7'b0111111: nibble = 4'h0;
      7'b0000110: nibble = 4'h1;
      7'b1011011: nibble = 4'h2;
      7'b1001111: nibble = 4'h3;
      7'b1100110: nibble = 4'h4;
      7'b1101101: nibble = 4'h5;
      7'b1111101: nibble = 4'h6;
      7'b0000111: nibble = 4'h7;
      7'b1111111: nibble = 4'h8;
      7'b1101111: nibble = 4'h9;
      7'b1110111: nibble = 4'hA;
      7'b1111100: nibble = 4'hB;
      7'b0111001: nibble = 4'hC;
      7'b1011110: nibble = 4'hD;
      7'b1111001: nibble = 4'hE;
      7'b1110001: nibble = 4'hF;
      default:    bad    = 1'b1;
    endcase
  end

  always_comb begin
    idx      = 2'd0;
    digit_ok = 1'b1;
    case (sample_anode)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: digit_ok = 1'b0;
    endcase
  end

  assign capture    = digit_ok && (stable_cnt == STABLE_MAX) && !held;
  assign frame_done = (seen == 4'b1111);

  // a capture coinciding with frame completion starts the next working frame
  always_comb begin
    seen_next = frame_done ? 4'b0000 : seen;
    err_next  = frame_done ? 4'b0000 : work_err;
    if (capture) begin
      seen_next[idx] = 1'b1;
      err_next[idx]  = bad;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work_data    <= '0;
      work_err     <= '0;
      seen         <= '0;
      data_out     <= '0;
      frame_valid  <= 1'b0;
      decode_error <= 1'b0;
      timeout_cnt  <= '0;
    end else begin
      frame_valid <= frame_done;
      seen        <= seen_next;
      work_err    <= err_next;
      if (capture) begin
        work_data[{idx, 2'b00} +: 4] <= nibble;
      end
      if (frame_done) begin
        data_out     <= work_data;
        decode_error <= |work_err;
        timeout_cnt  <= '0;
      end else if (timeout_cnt != TIMEOUT_MAX) begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end
    end
  end

  assign stale = (timeout_cnt == TIMEOUT_MAX);

`ifdef SEVEN_SEG_CAPTURE_DP_EN
  logic [3:0] work_dp;

  always_ff @(posedge clk) begin
    if (reset) begin
      work_dp <= '0;
      dp_out  <= '0;
    end else begin
      if (capture) begin
        work_dp[idx] <= ~sample_seg[7];
      end
      if (frame_done) begin
        dp_out <= work_dp;
      end
    end
  end
`else
  assign dp_out = 4'b0000;
`endif

endmodule

// File: tb/tb_seven_segment_capture.sv
// Self-checking bench for seven_segment_capture: directed scans plus randomized scans
// compared every cycle against a run-length / frame-assembly reference model.
module tb_seven_segment_capture;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 100;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anode;
  logic [7:0]  segment;
  logic [15:0] data_out;
  logic [3:0]  dp_out;
  logic        frame_valid;
  logic        decode_error;
  logic        stale;

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  logic [11:0] prev_x;
  int          run;
  int          tcnt;
  logic [3:0]  w_nib [4];
  logic        w_dp  [4];
  logic        w_err [4];
  bit          have  [4];
  logic [15:0] exp_data;
  logic [3:0]  exp_dp;
  logic        exp_err;
  logic        exp_fv;
  logic        exp_stale;

  always #5 clk = ~clk;

  seven_segment_capture #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .anode       (anode),
    .segment     (segment),
    .data_out    (data_out),
    .dp_out      (dp_out),
    .frame_valid (frame_valid),
    .decode_error(decode_error),
    .stale       (stale)
  );

  function automatic logic [7:0] mask_seg(input logic [7:0] s);
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    return s;
`else
    return {1'b0, s[6:0]};
`endif
  endfunction

  function automatic logic [3:0] dp_expect(input logic [3:0] m);
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    return m;
`else
    return 4'b0000 & m;
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    prev_x    = '0;
    run       = 1;
    tcnt      = 0;
    exp_data  = '0;
    exp_dp    = '0;
    exp_err   = 1'b0;
    exp_fv    = 1'b0;
    exp_stale = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_nib[i] = '0;
      w_dp[i]  = 1'b0;
      w_err[i] = 1'b0;
      have[i]  = 1'b0;
    end
  endtask

  // one clock edge of the model: frame completion, then the capture of a
  // digit that has been shown STABLE identical samples, then run-length update
  task automatic model_edge();
    logic [11:0] x;
    int lows;
    int d;
    logic found;
    if (reset) begin
      model_reset();
      return;
    end
    x = {anode, mask_seg(segment)};
    if (have[0] && have[1] && have[2] && have[3]) begin
      exp_fv  = 1'b1;
      exp_err = 1'b0;
      for (int i = 0; i < 4; i++) begin
        exp_data[4*i +: 4] = w_nib[i];
        exp_dp[i]          = w_dp[i];
        exp_err            = exp_err | w_err[i];
        have[i]            = 1'b0;
        w_err[i]           = 1'b0;
      end
      tcnt = 0;
    end else begin
      exp_fv = 1'b0;
      if (tcnt < TIMEOUT) tcnt++;
    end
    lows = 0;
    d    = 0;
    for (int i = 0; i < 4; i++) begin
      if (prev_x[8+i] == 1'b0) begin
        lows++;
        d = i;
      end
    end
    if (run == STABLE && lows == 1) begin
      found = 1'b0;
      w_nib[d] = 4'h0;
      for (int v = 0; v < 16; v++) begin
        if (SEG_TAB[v] == ~prev_x[6:0]) begin
          w_nib[d] = 4'(v);
          found    = 1'b1;
        end
      end
      w_err[d] = ~found;
      w_dp[d]  = ~prev_x[7];
      have[d]  = 1'b1;
    end
    if (x == prev_x) run++;
    else run = 1;
    prev_x    = x;
    exp_stale = (tcnt == TIMEOUT);
  endtask

  task automatic check_output();
    chk("frame_valid", 16'(frame_valid), 16'(exp_fv));
    chk("stale", 16'(stale), 16'(exp_stale));
    chk("data_out", data_out, exp_data);
    chk("dp_out", 16'(dp_out), 16'(dp_expect(exp_dp)));
    if (exp_fv) chk("decode_error", 16'(decode_error), 16'(exp_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_output();
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  task automatic show_raw(input int d, input logic [7:0] seg, input int cycles);
    anode   = ~(4'b0001 << d);
    segment = seg;
    repeat (cycles) tick();
  endtask

  task automatic apply_stimulus(input int d, input logic [3:0] nib, input logic dp, input int cycles);
    show_raw(d, ~{dp, SEG_TAB[nib]}, cycles);
  endtask

  task automatic scan(input logic [15:0] val, input logic [3:0] dp, input int hold);
    for (int d = 0; d < 4; d++) apply_stimulus(d, val[4*d +: 4], dp[d], hold);
  endtask

  initial begin
    reset   = 1'b1;
    anode   = 4'hF;
    segment = 8'hFF;
    model_reset();
    apply_reset(3);
    chk("reset_data", data_out, 16'h0000);
    chk("reset_dp", 16'(dp_out), 16'h0);
    chk("reset_err", 16'(decode_error), 16'h0);
    chk("reset_fv", 16'(frame_valid), 16'h0);
    chk("reset_stale", 16'(stale), 16'h0);

    $display("[TB] basic scan 1234");
    scan(16'h1234, 4'b0100, 8);
    chk("scan_1234", data_out, 16'h1234);
    chk("scan_1234_dp", 16'(dp_out), 16'(dp_expect(4'b0100)));

    $display("[TB] glitched scan ABCD");
    apply_stimulus(0, 4'hD, 1'b0, 8);
    apply_stimulus(1, 4'hC, 1'b0, 8);
    apply_stimulus(2, 4'hB, 1'b0, 5);
    show_raw(2, 8'h00, 2);
    apply_stimulus(2, 4'hB, 1'b0, 1);
    apply_stimulus(3, 4'hA, 1'b0, 8);
    chk("scan_abcd", data_out, 16'hABCD);

    $display("[TB] invalid digit 2");
    apply_stimulus(0, 4'h6, 1'b0, 8);
    apply_stimulus(1, 4'h9, 1'b0, 8);
    show_raw(2, ~{1'b0, 7'b0000001}, 8);
    apply_stimulus(3, 4'h3, 1'b0, 8);
    chk("invalid_data", data_out, 16'h3096);
    scan(16'h3596, 4'b0000, 8);
    chk("clean_after_invalid", data_out, 16'h3596);

    $display("[TB] reset mid-frame");
    apply_stimulus(0, 4'h1, 1'b1, 8);
    apply_stimulus(1, 4'h2, 1'b0, 8);
    apply_stimulus(2, 4'h3, 1'b1, 8);
    apply_reset(2);
    chk("midreset_data", data_out, 16'h0000);
    scan(16'h0F0F, 4'b1001, 8);
    chk("scan_0f0f", data_out, 16'h0F0F);

    $display("[TB] timeout");
    anode   = 4'hF;
    segment = 8'hFF;
    apply_reset(2);
    repeat (TIMEOUT - 1) tick();
    chk("stale_before", 16'(stale), 16'h0);
    tick();
    chk("stale_at_timeout", 16'(stale), 16'h1);
    scan(16'h5555, 4'b0000, 8);
    chk("stale_cleared", 16'(stale), 16'h0);
    chk("scan_5555", data_out, 16'h5555);

    $display("[TB] randomized scans");
    for (int f = 0; f < 12; f++) begin
      for (int d = 0; d < 4; d++) begin
        int hold;
        int kind;
        hold = $urandom_range(2, 9);
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
          show_raw(d, 8'($urandom), hold);
        end else if (kind == 1) begin
          anode   = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'b1010;
          segment = 8'($urandom);
          repeat (hold) tick();
          apply_stimulus(d, 4'($urandom), 1'($urandom), 6);
        end else begin
          apply_stimulus(d, 4'($urandom), 1'($urandom), hold);
        end
      end
    end
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
